// File: rtl/vending_ctrl_n.sv
// Vending machine controller.
// Takes 5- and 10-unit coins up to a credit ceiling and vends the lowest-index
// affordable, in-stock selected item. Remaining credit is returned as a greedy
// sequence of change10/change5 pulses, one coin per cycle.
// Legal parameter sets: prices and MAX_CREDIT are multiples of 5,
// 0 < price <= MAX_CREDIT, MAX_CREDIT < 2**CREDIT_W, STOCK_INIT < 2**STOCK_W.
module vending_ctrl_n #(
   parameter int                              NUM_ITEMS  = 3,
   parameter int                              CREDIT_W   = 6,
   parameter int                              MAX_CREDIT = 40,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0]   PRICES     = {6'd20, 6'd15, 6'd10},
   parameter int                              STOCK_W    = 4,
   parameter int                              STOCK_INIT = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 coin5,
   input  logic                 coin10,
   input  logic [NUM_ITEMS-1:0] sel,
   input  logic                 cancel,
   input  logic                 restock,
   output logic [NUM_ITEMS-1:0] available,
   output logic [NUM_ITEMS-1:0] sold_out,
   output logic [NUM_ITEMS-1:0] drop,
   output logic                 change5,
   output logic                 change10,
   output logic                 coin_reject,
   output logic [CREDIT_W-1:0]  credit,
   output logic [1:0]           state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DROP    = 2'd2,
      CHANGE  = 2'd3
   } state_t;

   // Wide enough to hold credit plus the largest single-cycle coin value (15).
   localparam int                   SUM_W     = CREDIT_W + 5;
   localparam logic [CREDIT_W-1:0]  FIVE      = CREDIT_W'(5);
   localparam logic [CREDIT_W-1:0]  TEN       = CREDIT_W'(10);
   localparam logic [STOCK_W-1:0]   STOCK_ONE = STOCK_W'(1);
   localparam logic [STOCK_W-1:0]   STOCK_RLD = STOCK_W'(STOCK_INIT);

   state_t                 state_q;
   state_t                 state_d;
   logic [CREDIT_W-1:0]    credit_q;
   logic [CREDIT_W-1:0]    credit_d;
   logic [STOCK_W-1:0]     stock_q [NUM_ITEMS];
   logic [CREDIT_W-1:0]    price   [NUM_ITEMS];

   logic [NUM_ITEMS-1:0]   sel_onehot;
   logic [NUM_ITEMS-1:0]   buy;
   logic [CREDIT_W-1:0]    sel_price;
   logic [CREDIT_W-1:0]    buy_price;
   logic                   buy_valid;
   logic [3:0]             coin_val;
   logic                   accept_state;
   logic [CREDIT_W-1:0]    base_credit;
   logic [SUM_W-1:0]       coin_sum;
   logic                   coin_ok;

   logic [NUM_ITEMS-1:0]   drop_d;
   logic                   change5_d;
   logic                   change10_d;
   logic                   reject_d;

   // Per-item price lookup and status flags.
   for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_item
      assign price[g]     = PRICES[g*CREDIT_W +: CREDIT_W];
      assign available[g] = (state_q == COLLECT) && (credit_q >= price[g]) &&
                            (stock_q[g] != '0);
      assign sold_out[g]  = (stock_q[g] == '0);
   end

   assign credit = credit_q;
   assign state  = state_q;

   // Pick the lowest-index selected item that is currently available.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      sel_onehot = '0;
      sel_price  = '0;
      for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
         if (sel[i] && available[i]) begin
            sel_onehot    = '0;
            sel_onehot[i] = 1'b1;
            sel_price     = price[i];
         end
      end
   end

   // Cancel overrides any same-cycle selection.
   assign buy       = cancel ? '0 : sel_onehot;
   assign buy_price = cancel ? '0 : sel_price;
   assign buy_valid = |buy;

   // Coin acceptance is judged against the credit left after any purchase.
   assign coin_val     = (coin5 ? 4'd5 : 4'd0) + (coin10 ? 4'd10 : 4'd0);
   assign accept_state = (state_q == IDLE) || ((state_q == COLLECT) && !cancel);
   assign base_credit  = credit_q - buy_price;
   assign coin_sum     = SUM_W'(base_credit) + SUM_W'(coin_val);
   assign coin_ok      = accept_state && (coin_val != 4'd0) &&
                         (coin_sum <= SUM_W'(MAX_CREDIT));

   // Next state, next credit and the next values of the registered outputs.
   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      drop_d   = '0;
      case (state_q)
         IDLE: begin
            if (coin_ok) begin
               state_d  = COLLECT;
               credit_d = CREDIT_W'(coin_sum);
            end
         end
         COLLECT: begin
            if (cancel) begin
               state_d = CHANGE;
            end else begin
               credit_d = coin_ok ? CREDIT_W'(coin_sum) : base_credit;
               if (buy_valid) begin
                  state_d = DROP;
                  drop_d  = buy;
               end else if (credit_d == '0) begin
                  state_d = IDLE;
               end
            end
         end
         DROP: begin
            state_d = (credit_q != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            // Greedy: hand back a 10 while possible, otherwise the last 5.
            if (credit_q >= TEN) begin
               credit_d = credit_q - TEN;
            end else begin
               credit_d = '0;
            end
            if (credit_d == '0) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d  = IDLE;
            credit_d = '0;
         end
      endcase
   end

   // Change pulses are a Moore decode of the state/credit the FSM is entering.
   assign change10_d = (state_d == CHANGE) && (credit_d >= TEN);
   assign change5_d  = (state_d == CHANGE) && (credit_d == FIVE);
   assign reject_d   = (coin_val != 4'd0) && !coin_ok;

   // FSM, credit, stock and registered pulse outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         credit_q    <= '0;
         drop        <= '0;
         change5     <= 1'b0;
         change10    <= 1'b0;
         coin_reject <= 1'b0;
         // NOTE: stock is a few flops rather than a RAM, so it is reset with the rest.
         for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_q[i] <= STOCK_RLD;
         end
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         state_q     <= state_d;
         credit_q    <= credit_d;
         drop        <= drop_d;
         change5     <= change5_d;
         change10    <= change10_d;
         coin_reject <= reject_d;
         for (int i = 0; i < NUM_ITEMS; i++) begin
            if (restock) begin
               stock_q[i] <= STOCK_RLD;
            end else if (buy[i]) begin
               stock_q[i] <= stock_q[i] - STOCK_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_vending_ctrl_n.sv
// Directed bench for vending_ctrl_n with default parameters
// (price0=10, price1=15, price2=20, MAX_CREDIT=40, STOCK_INIT=2).
// Each step drives inputs, queues the output snapshot expected after the next
// rising edge, then pops and compares it 1 ns after that edge.
module tb_vending_ctrl_n;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b1;
   logic       coin5   = 1'b0;
   logic       coin10  = 1'b0;
   logic [2:0] sel     = 3'b000;
   logic       cancel  = 1'b0;
   logic       restock = 1'b0;
   logic [2:0] available;
   logic [2:0] sold_out;
   logic [2:0] drop;
   logic       change5;
   logic       change10;
   logic       coin_reject;
   logic [5:0] credit;
   logic [1:0] state;

   typedef struct packed {
      logic [1:0] st;
      logic [5:0] cr;
      logic [2:0] av;
      logic [2:0] so;
      logic [2:0] dr;
      logic       c10;
      logic       c5;
      logic       rej;
   } snap_t;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_COLL = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;
   localparam logic [1:0] S_CHG  = 2'd3;

   snap_t exp_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;

   vending_ctrl_n dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .coin5       (coin5),
      .coin10      (coin10),
      .sel         (sel),
      .cancel      (cancel),
      .restock     (restock),
      .available   (available),
      .sold_out    (sold_out),
      .drop        (drop),
      .change5     (change5),
      .change10    (change10),
      .coin_reject (coin_reject),
      .credit      (credit),
      .state       (state)
   );

   always #5 clk = ~clk;

   function automatic snap_t x(input logic [1:0] st, input int cr, input logic [2:0] av,
                               input logic [2:0] so, input logic [2:0] dr,
                               input logic c10, input logic c5, input logic rej);
      x = '{st: st, cr: 6'(cr), av: av, so: so, dr: dr, c10: c10, c5: c5, rej: rej};
   endfunction

   task automatic expect_next(input string tag, input snap_t e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // Pop the oldest expectation and compare it with the live outputs.
   task automatic check();
      snap_t e;
      snap_t o;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = '{st: state, cr: credit, av: available, so: sold_out, dr: drop,
            c10: change10, c5: change5, rej: coin_reject};
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed st=%0d cr=%0d av=%b so=%b drop=%b c10=%b c5=%b rej=%b, expected st=%0d cr=%0d av=%b so=%b drop=%b c10=%b c5=%b rej=%b",
                t, o.st, o.cr, o.av, o.so, o.dr, o.c10, o.c5, o.rej,
                e.st, e.cr, e.av, e.so, e.dr, e.c10, e.c5, e.rej);
      end
   endtask

   // One clocked step: drive inputs, queue expectation, clock, compare.
   task automatic step(input string tag, input logic c5i, input logic c10i,
                       input logic [2:0] s, input logic can, input logic rs,
                       input snap_t e);
      coin5   = c5i;
      coin10  = c10i;
      sel     = s;
      cancel  = can;
      restock = rs;
      expect_next(tag, e);
      @(posedge clk);
      #1;
      check();
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      expect_next("reset_state", x(S_IDLE, 0, 3'b000, 3'b000, 3'b000, 0, 0, 0));
      check();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Three coin5, cancel, greedy change 10 then 5.
      step("a_coin5_1", 1, 0, 3'b000, 0, 0, x(S_COLL,  5, 3'b000, 3'b000, 3'b000, 0, 0, 0));
      step("a_coin5_2", 1, 0, 3'b000, 0, 0, x(S_COLL, 10, 3'b001, 3'b000, 3'b000, 0, 0, 0));
      step("a_coin5_3", 1, 0, 3'b000, 0, 0, x(S_COLL, 15, 3'b011, 3'b000, 3'b000, 0, 0, 0));
      step("a_cancel",  0, 0, 3'b000, 1, 0, x(S_CHG,  15, 3'b000, 3'b000, 3'b000, 1, 0, 0));
      step("a_change5", 0, 0, 3'b000, 0, 0, x(S_CHG,   5, 3'b000, 3'b000, 3'b000, 0, 1, 0));
      step("a_idle",    0, 0, 3'b000, 0, 0, x(S_IDLE,  0, 3'b000, 3'b000, 3'b000, 0, 0, 0));

      // Credit 30, buy item2, change 10.
      step("b_coin10_1", 0, 1, 3'b000, 0, 0, x(S_COLL, 10, 3'b001, 3'b000, 3'b000, 0, 0, 0));
      step("b_coin10_2", 0, 1, 3'b000, 0, 0, x(S_COLL, 20, 3'b111, 3'b000, 3'b000, 0, 0, 0));
      step("b_coin10_3", 0, 1, 3'b000, 0, 0, x(S_COLL, 30, 3'b111, 3'b000, 3'b000, 0, 0, 0));
      step("b_sel2",     0, 0, 3'b100, 0, 0, x(S_DROP, 10, 3'b000, 3'b000, 3'b100, 0, 0, 0));
      step("b_change10", 0, 0, 3'b000, 0, 0, x(S_CHG,  10, 3'b000, 3'b000, 3'b000, 1, 0, 0));
      step("b_idle",     0, 0, 3'b000, 0, 0, x(S_IDLE,  0, 3'b000, 3'b000, 3'b000, 0, 0, 0));

      // Exact-price purchases drain item0; selection of a sold-out item is ignored.
      step("c_coin10_1",     0, 1, 3'b000, 0, 0, x(S_COLL, 10, 3'b001, 3'b000, 3'b000, 0, 0, 0));
      step("c_sel0_1",       0, 0, 3'b001, 0, 0, x(S_DROP,  0, 3'b000, 3'b000, 3'b001, 0, 0, 0));
      step("c_idle_1",       0, 0, 3'b000, 0, 0, x(S_IDLE,  0, 3'b000, 3'b000, 3'b000, 0, 0, 0));
      step("c_coin10_2",     0, 1, 3'b000, 0, 0, x(S_COLL, 10, 3'b001, 3'b000, 3'b000, 0, 0, 0));
      step("c_sel0_2",       0, 0, 3'b001, 0, 0, x(S_DROP,  0, 3'b000, 3'b001, 3'b001, 0, 0, 0));
      step("c_idle_2",       0, 0, 3'b000, 0, 0, x(S_IDLE,  0, 3'b000, 3'b001, 3'b000, 0, 0, 0));
      step("c_coin10_3",     0, 1, 3'b000, 0, 0, x(S_COLL, 10, 3'b000, 3'b001, 3'b000, 0, 0, 0));
      step("c_sel0_ignored", 0, 0, 3'b001, 0, 0, x(S_COLL, 10, 3'b000, 3'b001, 3'b000, 0, 0, 0));
      step("c_restock",      0, 0, 3'b000, 0, 1, x(S_COLL, 10, 3'b001, 3'b000, 3'b000, 0, 0, 0));
      step("c_cancel",       0, 0, 3'b000, 1, 0, x(S_CHG,  10, 3'b000, 3'b000, 3'b000, 1, 0, 0));
      step("c_idle_3",       0, 0, 3'b000, 0, 0, x(S_IDLE,  0, 3'b000, 3'b000, 3'b000, 0, 0, 0));

      // Fill to the ceiling, overflow coin refused, cancel beats select.
      step("d_coin10_1",   0, 1, 3'b000, 0, 0, x(S_COLL, 10, 3'b001, 3'b000, 3'b000, 0, 0, 0));
      step("d_coin10_2",   0, 1, 3'b000, 0, 0, x(S_COLL, 20, 3'b111, 3'b000, 3'b000, 0, 0, 0));
      step("d_coin10_3",   0, 1, 3'b000, 0, 0, x(S_COLL, 30, 3'b111, 3'b000, 3'b000, 0, 0, 0));
      step("d_coin10_max", 0, 1, 3'b000, 0, 0, x(S_COLL, 40, 3'b111, 3'b000, 3'b000, 0, 0, 0));
      step("d_reject",     0, 1, 3'b000, 0, 0, x(S_COLL, 40, 3'b111, 3'b000, 3'b000, 0, 0, 1));
      step("d_sel_cancel", 0, 0, 3'b001, 1, 0, x(S_CHG,  40, 3'b000, 3'b000, 3'b000, 1, 0, 0));
      step("d_chg_30",     0, 0, 3'b000, 0, 0, x(S_CHG,  30, 3'b000, 3'b000, 3'b000, 1, 0, 0));
      step("d_chg_20",     0, 0, 3'b000, 0, 0, x(S_CHG,  20, 3'b000, 3'b000, 3'b000, 1, 0, 0));
      step("d_chg_10",     0, 0, 3'b000, 0, 0, x(S_CHG,  10, 3'b000, 3'b000, 3'b000, 1, 0, 0));
      step("d_idle",       0, 0, 3'b000, 0, 0, x(S_IDLE,  0, 3'b000, 3'b000, 3'b000, 0, 0, 0));

      // Two selects: lowest index wins; a coin during DROP is refused.
      step("e_coin15",       1, 1, 3'b000, 0, 0, x(S_COLL, 15, 3'b011, 3'b000, 3'b000, 0, 0, 0));
      step("e_sel_011",      0, 0, 3'b011, 0, 0, x(S_DROP,  5, 3'b000, 3'b000, 3'b001, 0, 0, 0));
      step("e_coin_in_drop", 1, 0, 3'b000, 0, 0, x(S_CHG,   5, 3'b000, 3'b000, 3'b000, 0, 1, 1));
      step("e_idle",         0, 0, 3'b000, 0, 0, x(S_IDLE,  0, 3'b000, 3'b000, 3'b000, 0, 0, 0));

      // Purchase with a same-cycle coin, then reset in the middle of change.
      step("f_coin10_1",   0, 1, 3'b000, 0, 0, x(S_COLL, 10, 3'b001, 3'b000, 3'b000, 0, 0, 0));
      step("f_coin10_2",   0, 1, 3'b000, 0, 0, x(S_COLL, 20, 3'b111, 3'b000, 3'b000, 0, 0, 0));
      step("f_coin10_3",   0, 1, 3'b000, 0, 0, x(S_COLL, 30, 3'b111, 3'b000, 3'b000, 0, 0, 0));
      step("f_sel0_coin5", 1, 0, 3'b001, 0, 0, x(S_DROP, 25, 3'b000, 3'b001, 3'b001, 0, 0, 0));
      step("f_change25",   0, 0, 3'b000, 0, 0, x(S_CHG,  25, 3'b000, 3'b001, 3'b000, 1, 0, 0));
      coin5 = 1'b0; coin10 = 1'b0; sel = 3'b000; cancel = 1'b0; restock = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      expect_next("f_async_reset", x(S_IDLE, 0, 3'b000, 3'b000, 3'b000, 0, 0, 0));
      check();
      @(posedge clk);
      #1;
      expect_next("f_reset_held", x(S_IDLE, 0, 3'b000, 3'b000, 3'b000, 0, 0, 0));
      check();
      @(negedge clk) rst_n = 1'b1;

      // First edge after release acts as IDLE.
      step("g_first_coin5", 1, 0, 3'b000, 0, 0, x(S_COLL, 5, 3'b000, 3'b000, 3'b000, 0, 0, 0));
      step("g_cancel",      0, 0, 3'b000, 1, 0, x(S_CHG,  5, 3'b000, 3'b000, 3'b000, 0, 1, 0));
      step("g_idle",        0, 0, 3'b000, 0, 0, x(S_IDLE, 0, 3'b000, 3'b000, 3'b000, 0, 0, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
